// File: rtl/tsip_pkg.sv
// ----------------------------------------------------------------------------
// tsip_pkg
// Shared TSIP definitions for the Thunderbolt link: framing byte values, the
// packet IDs used by the timing control logic, and the transmit FSM state
// encoding. Imported by the transmitter and by the existing receiver.
// No ports (package).
// ----------------------------------------------------------------------------
package tsip_pkg;

  localparam logic [7:0] TSIP_DLE        = 8'h10;
  localparam logic [7:0] TSIP_ETX        = 8'h03;
  localparam logic [7:0] TSIP_ID_TIMING  = 8'h8F;
  localparam logic [7:0] TSIP_SUB_TIMING = 8'hAB;

  // Each state names the byte currently being serialised. IDLE means no packet.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_DLE,
    ST_ID,
    ST_ID_STUFF,
    ST_PAYLOAD,
    ST_PL_STUFF,
    ST_TRL_DLE,
    ST_ETX
  } txState_e;

  // An ID equal to a framing byte cannot be sent unambiguously.
  function automatic logic isFramingByte(input logic [7:0] b);
    return (b == TSIP_DLE) || (b == TSIP_ETX);
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// ----------------------------------------------------------------------------
// uart_tx_byte
// Serialises one byte per i_send: start bit, 8 data bits LSB first, optional
// odd parity bit, stop bit. Every bit lasts CLKS_PER_BIT clocks.
// Optional feature macro: TSIP_TX_ODD_PARITY_EN (8-O-1 instead of 8-N-1).
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset (line forced idle high)
//   i_send   load i_byte; honoured only while o_busy is low
//   i_byte   byte to transmit
//   o_busy   high while a frame is on the line, low during the final stop cycle
//   o_tx     serial line, idle high
// ----------------------------------------------------------------------------
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_send,
  input  logic [7:0] i_byte,
  output logic       o_busy,
  output logic       o_tx
);

`ifdef TSIP_TX_ODD_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] BIT_LAST = 4'(NBITS - 1);

  logic                 active_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [3:0]           bitIdx_q;
  logic [NBITS-2:0]     shift_q;
  logic                 tx_q;
  logic [NBITS-2:0]     frameTail;
  logic                 lastTick;

  // Everything after the start bit, in transmit order from bit 0 upward.
`ifdef TSIP_TX_ODD_PARITY_EN
  assign frameTail = {1'b1, ~^i_byte, i_byte};
`else
  assign frameTail = {1'b1, i_byte};
`endif

  // Reporting free during the last stop cycle lets the next byte's start bit
  // follow immediately, so consecutive bytes leave no idle gap.
  assign lastTick = active_q && (timer_q == TIMER_LAST) && (bitIdx_q == BIT_LAST);
  assign o_busy   = active_q && !lastTick;
  assign o_tx     = tx_q;

  // Bit timer and shifter. A load drives the start bit out on the next cycle;
  // each timer wrap moves the next bit onto the line until the stop bit ends.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      active_q <= 1'b0;
      timer_q  <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else if (i_send && !o_busy) begin
      active_q <= 1'b1;
      timer_q  <= '0;
      bitIdx_q <= '0;
      shift_q  <= frameTail;
      tx_q     <= 1'b0;
    end else if (active_q) begin
      if (timer_q == TIMER_LAST) begin
        timer_q <= '0;
        if (bitIdx_q == BIT_LAST) begin
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          tx_q     <= shift_q[0];
          shift_q  <= {1'b1, shift_q[NBITS-2:1]};
          bitIdx_q <= bitIdx_q + 4'd1;
        end
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tsip_packet_tx.sv
// ----------------------------------------------------------------------------
// tsip_packet_tx
// Frames a TSIP command packet (DLE, ID, payload, DLE, ETX), doubles any ID or
// payload byte equal to DLE, and hands bytes to uart_tx_byte.
// Optional feature macro: TSIP_TX_ODD_PARITY_EN (passed through to the UART).
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_start         request one packet (honoured only when idle)
//   i_id, i_len     packet ID and payload length, latched on accepted start
//   i_pl_data/i_pl_valid/o_pl_ready  payload byte stream
//   o_tx            UART line, idle high
//   o_busy          packet in progress
//   o_done          one-cycle pulse after the final stop bit
//   o_err           one-cycle pulse when a start is rejected (ID is DLE/ETX)
// ----------------------------------------------------------------------------
module tsip_packet_tx #(
  parameter int CLKS_PER_BIT = 1042,
  parameter int LEN_W        = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [7:0]       i_id,
  input  logic [LEN_W-1:0] i_len,
  input  logic [7:0]       i_pl_data,
  input  logic             i_pl_valid,
  output logic             o_pl_ready,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);
  import tsip_pkg::*;

  txState_e         state_q, state_d;
  logic [7:0]       id_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             plDle_q, plDle_d;
  logic             busy_q, done_q, err_q;

  logic             serBusy, serSend;
  logic [7:0]       serByte;
  logic             plReady, startOk, owed, plPhase, needStuff;

  // Next-byte selection. Decisions are taken in the serialiser's final stop
  // cycle so the following byte goes out gaplessly. plPhase covers every point
  // where the next byte is either payload or, once none is owed, the trailer.
  always_comb begin
    serSend   = 1'b0;
    serByte   = TSIP_DLE;
    plReady   = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    plDle_d   = plDle_q;
    startOk   = i_start && !isFramingByte(i_id);
    owed      = (cnt_q != len_q);
    needStuff = ((state_q == ST_ID) && (id_q == TSIP_DLE)) ||
                ((state_q == ST_PAYLOAD) && plDle_q);
    plPhase   = ((state_q == ST_ID) && (id_q != TSIP_DLE)) ||
                (state_q == ST_ID_STUFF) ||
                ((state_q == ST_PAYLOAD) && !plDle_q) ||
                (state_q == ST_PL_STUFF);

    case (state_q)
      ST_IDLE: begin
        if (startOk) begin
          serSend = 1'b1;
          serByte = TSIP_DLE;
          state_d = ST_HDR_DLE;
        end
      end
      ST_HDR_DLE: begin
        if (!serBusy) begin
          serSend = 1'b1;
          serByte = id_q;
          state_d = ST_ID;
        end
      end
      ST_TRL_DLE: begin
        if (!serBusy) begin
          serSend = 1'b1;
          serByte = TSIP_ETX;
          state_d = ST_ETX;
        end
      end
      ST_ETX: begin
        if (!serBusy) begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase

    if (!serBusy && needStuff) begin
      serSend = 1'b1;
      serByte = TSIP_DLE;
      plDle_d = 1'b0;
      state_d = (state_q == ST_ID) ? ST_ID_STUFF : ST_PL_STUFF;
    end else if (!serBusy && plPhase) begin
      if (owed) begin
        plReady = 1'b1;
        state_d = ST_PAYLOAD;
        plDle_d = 1'b0;
        if (i_pl_valid) begin
          serSend = 1'b1;
          serByte = i_pl_data;
          cnt_d   = cnt_q + 1'b1;
          plDle_d = (i_pl_data == TSIP_DLE);
        end
      end else begin
        serSend = 1'b1;
        serByte = TSIP_DLE;
        state_d = ST_TRL_DLE;
      end
    end
  end

  // Packet FSM and registered status outputs. Start parameters are latched
  // only on an accepted start; busy drops together with the done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      plDle_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      plDle_q <= plDle_d;
      done_q  <= (state_q == ST_ETX) && !serBusy;
      err_q   <= (state_q == ST_IDLE) && i_start && !startOk;
      if ((state_q == ST_IDLE) && startOk) begin
        id_q    <= i_id;
        len_q   <= i_len;
        cnt_q   <= '0;
        plDle_q <= 1'b0;
        busy_q  <= 1'b1;
      end else if ((state_q == ST_ETX) && !serBusy) begin
        busy_q  <= 1'b0;
      end
    end
  end

  assign o_pl_ready = plReady;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uTx (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_send (serSend),
    .i_byte (serByte),
    .o_busy (serBusy),
    .o_tx   (o_tx)
  );

endmodule

// File: tb/tb_tsip_packet_tx.sv
// ----------------------------------------------------------------------------
// tb_tsip_packet_tx
// Self-checking bench for tsip_packet_tx with a short bit time. A line monitor
// decodes UART frames from o_tx; expected wire bytes and packet duration are
// derived from the TSIP framing rules. Honours TSIP_TX_ODD_PARITY_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tsip_packet_tx;

  localparam int CPB = 4;
  localparam int LW  = 6;
`ifdef TSIP_TX_ODD_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic          clk;
  logic          rstN;
  logic          start;
  logic [7:0]    id;
  logic [LW-1:0] len;
  logic [7:0]    plData;
  logic          plValid;
  logic          plReady, tx, busy, done, err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] plBuf [64];

  tsip_packet_tx #(
    .CLKS_PER_BIT(CPB),
    .LEN_W       (LW)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rstN),
    .i_start   (start),
    .i_id      (id),
    .i_len     (len),
    .i_pl_data (plData),
    .i_pl_valid(plValid),
    .o_pl_ready(plReady),
    .o_tx      (tx),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err)
  );

  // Free-running clock and a cycle counter used for latency and duration.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: finds a start bit, samples each bit mid-way, checks the
  // parity and stop bits, and queues the decoded byte.
  logic [7:0] rxQ [$];
  int         rxStartCyc = -1;
  int         rxFrameErr = 0;
  bit         monActive  = 1'b0;
  int         monCnt     = 0;
  int         monBit     = 0;
  logic [7:0] monByte    = 8'h00;

  always @(negedge clk) begin
    if (!rstN) begin
      monActive = 1'b0;
    end else if (!monActive) begin
      if (tx === 1'b0) begin
        monActive = 1'b1;
        monCnt    = 0;
        if (rxStartCyc < 0) rxStartCyc = cyc;
      end
    end else begin
      monCnt++;
      if ((monCnt % CPB) == CPB / 2) begin
        monBit = monCnt / CPB;
        if (monBit == 0) begin
          if (tx !== 1'b0) rxFrameErr++;
        end else if (monBit <= 8) begin
          monByte[monBit-1] = tx;
        end else if (monBit < NB - 1) begin
          if (tx !== ~^monByte) rxFrameErr++;
        end else begin
          if (tx !== 1'b1) rxFrameErr++;
          rxQ.push_back(monByte);
          monActive = 1'b0;
        end
      end
    end
  end

  // Hard stop in case something upstream never returns.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Sends one packet with plBuf[0..plen-1] as payload, optionally withholding
  // valid for gapLen ready cycles before byte gapIdx, and checks the result.
  // A busy-time start with a bad ID and one with a good ID are slipped in.
  task automatic applyStimulus(input string name, input logic [7:0] pid,
                               input int plen, input int gapIdx, input int gapLen);
    logic [7:0] expQ [$];
    int  expCycles, limit, idx, gapLeft, waitCnt, c0;
    int  readySeen, errSeen, doneCnt, doneCyc, acceptBusy, busyAtDone;
    bit  willXfer;
    logic [31:0] obs;

    expQ.delete();
    expQ.push_back(8'h10);
    expQ.push_back(pid);
    if (pid == 8'h10) expQ.push_back(8'h10);
    for (int i = 0; i < plen; i++) begin
      expQ.push_back(plBuf[i]);
      if (plBuf[i] == 8'h10) expQ.push_back(8'h10);
    end
    expQ.push_back(8'h10);
    expQ.push_back(8'h03);
    expCycles = expQ.size() * NB * CPB + ((gapIdx < plen) ? gapLen : 0);
    limit     = expCycles + 200;

    rxQ.delete();
    rxStartCyc = -1;
    rxFrameErr = 0;
    readySeen  = 0;
    errSeen    = 0;
    doneCnt    = 0;
    doneCyc    = -1;
    busyAtDone = 1;

    @(negedge clk);
    start = 1'b1;
    id    = pid;
    len   = LW'(plen);
    c0    = cyc;
    @(negedge clk);
    start      = 1'b0;
    id         = 8'($urandom);
    len        = LW'($urandom);
    acceptBusy = int'(busy);

    idx      = 0;
    gapLeft  = gapLen;
    willXfer = 1'b0;
    waitCnt  = 0;
    while (1) begin
      if (willXfer) idx++;
      if (idx < plen) begin
        if (idx == gapIdx && gapLeft > 0) begin
          plValid = 1'b0;
          plData  = 8'($urandom);
          if (plReady) gapLeft--;
        end else begin
          plValid = 1'b1;
          plData  = plBuf[idx];
        end
      end else begin
        plValid = 1'b0;
        plData  = 8'($urandom);
      end
      willXfer = plValid && plReady;
      if (plReady) readySeen++;
      if (err) errSeen++;
      if (done) begin
        doneCnt++;
        if (doneCyc < 0) begin
          doneCyc    = cyc;
          busyAtDone = int'(busy);
        end
      end
      if (waitCnt == 30) begin
        start = 1'b1;
        id    = 8'h10;
      end else if (waitCnt == 31) begin
        start = 1'b1;
        id    = 8'h55;
      end else begin
        start = 1'b0;
      end
      if (doneCyc >= 0 && (cyc - doneCyc) >= 10) break;
      if (waitCnt >= limit) break;
      @(negedge clk);
      waitCnt++;
    end
    start = 1'b0;

    checkOutput({name, " busyAfterStart"}, acceptBusy, 1);
    checkOutput({name, " startLatency"}, rxStartCyc - c0, 1);
    checkOutput({name, " byteCount"}, rxQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      obs = (i < rxQ.size()) ? {24'h0, rxQ[i]} : 32'hxxxxxxxx;
      checkOutput($sformatf("%s byte%0d", name, i), obs, {24'h0, expQ[i]});
    end
    checkOutput({name, " frameErrors"}, rxFrameErr, 0);
    checkOutput({name, " doneCount"}, doneCnt, 1);
    checkOutput({name, " duration"}, doneCyc - rxStartCyc, expCycles);
    checkOutput({name, " busyAtDone"}, busyAtDone, 0);
    checkOutput({name, " busyAfter"}, busy, 0);
    checkOutput({name, " txIdle"}, tx, 1);
    checkOutput({name, " errWhileBusy"}, errSeen, 0);
    if (plen == 0) checkOutput({name, " readyNever"}, readySeen, 0);
    else           checkOutput({name, " readyEnough"}, readySeen >= plen, 1);
  endtask

  initial begin
    int lowCnt, errCnt, busyCnt, doneSeen, plen, gapIdx, gapLen;
    logic [7:0] pid;

    rstN    = 1'b0;
    start   = 1'b0;
    id      = 8'h00;
    len     = '0;
    plData  = 8'h00;
    plValid = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("reset tx", tx, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset ready", plReady, 0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // Two payload bytes, the second one DLE
    plBuf[0] = 8'hAB;
    plBuf[1] = 8'h10;
    applyStimulus("twoByte", 8'h8E, 2, 99, 0);

    // Empty payload
    applyStimulus("empty", 8'h1F, 0, 99, 0);

    // Rejected starts: ID equal to DLE, then ETX
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b1;
      id    = (k == 0) ? 8'h10 : 8'h03;
      len   = LW'(3);
      @(negedge clk);
      start = 1'b0;
      checkOutput($sformatf("reject%0d errPulse", k), err, 1);
      checkOutput($sformatf("reject%0d busy", k), busy, 0);
      lowCnt  = 0;
      errCnt  = 0;
      busyCnt = 0;
      repeat (20) begin
        @(negedge clk);
        if (tx !== 1'b1) lowCnt++;
        if (err) errCnt++;
        if (busy) busyCnt++;
      end
      checkOutput($sformatf("reject%0d txHigh", k), lowCnt, 0);
      checkOutput($sformatf("reject%0d errOnce", k), errCnt, 0);
      checkOutput($sformatf("reject%0d busyLow", k), busyCnt, 0);
    end

    // Three payload bytes with a 37-cycle hold before the second
    for (int i = 0; i < 3; i++) plBuf[i] = 8'($urandom);
    applyStimulus("gap37", 8'h8F, 3, 1, 37);

    // Parity-sensitive payload
    plBuf[0] = 8'h00;
    plBuf[1] = 8'h01;
    applyStimulus("parity", 8'hAB, 2, 99, 0);

    // Reset while the ID byte's data bits are on the line
    @(negedge clk);
    start = 1'b1;
    id    = 8'h00;
    len   = LW'(1);
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    checkOutput("midReset txLowBefore", tx, 0);
    #1 rstN = 1'b0;
    #1;
    checkOutput("midReset txHigh", tx, 1);
    checkOutput("midReset busy", busy, 0);
    checkOutput("midReset ready", plReady, 0);
    doneSeen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    rstN = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("midReset noDone", doneSeen, 0);
    for (int i = 0; i < 4; i++) plBuf[i] = 8'($urandom);
    plBuf[2] = 8'h10;
    applyStimulus("afterReset", 8'h8F, 4, 99, 0);

    // Maximum payload length, every third byte DLE
    for (int i = 0; i < 63; i++) plBuf[i] = (i % 3 == 0) ? 8'h10 : 8'($urandom);
    applyStimulus("maxLen", 8'h8E, 63, 40, 5);

    // Randomised packets
    for (int n = 0; n < 16; n++) begin
      pid = 8'($urandom);
      while (pid == 8'h10 || pid == 8'h03) pid = 8'($urandom);
      plen = $urandom_range(0, 9);
      for (int i = 0; i < plen; i++)
        plBuf[i] = ($urandom_range(0, 3) == 0) ? 8'h10 : 8'($urandom);
      gapIdx = $urandom_range(0, 9);
      gapLen = $urandom_range(0, 25);
      applyStimulus($sformatf("rand%0d", n), pid, plen, gapIdx, gapLen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tsip_packet_tx.md
Name: tsip_packet_tx

Overview:
- Transmits TSIP command packets from the FPGA to the Trimble Thunderbolt on the UART TX line (o_tx at the top level).
- Frames each packet and applies DLE stuffing to the packet ID and payload bytes.
- Serialises bytes as 8-N-1, LSB first.
- Control logic starts a packet, then supplies payload bytes over a valid/ready stream. Any bit-duration gaps are absorbed as idle-high.

Parameters:
- CLKS_PER_BIT, 1042, clock cycles per UART bit (i_clk cycles).
- LEN_W, 6, width of payload length; max payload 2^LEN_W-1 bytes.

Ports:
- i_clk  in  1  system clock (10 MHz)
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle request to send one packet
- i_id  in  8  TSIP packet ID, sampled on accepted i_start
- i_len  in  LEN_W  number of payload bytes, sampled on accepted i_start
- i_pl_data  in  8  payload byte
- i_pl_valid  in  1  payload byte valid
- o_pl_ready  out  1  payload byte accepted when valid&&ready
- o_tx  out  1  UART serial output, idle high
- o_busy  out  1  packet in progress
- o_done  out  1  one-cycle pulse when the last stop bit completes
- o_err  out  1  one-cycle pulse when i_start is rejected

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: o_tx=1, o_busy=0, o_done=0, o_err=0, o_pl_ready=0, FSM=IDLE, all counters 0.
- Reset mid-packet aborts immediately: o_tx goes high asynchronously and no o_done is issued.
- Wire format: 0x10, ID, payload[0..len-1], 0x10, 0x03.
  - Any ID or payload byte equal to 0x10 is sent twice.
  - The framing DLE/ETX bytes are never stuffed.
- Accepting a start:
  - i_start is accepted only in IDLE.
  - If i_id is 0x10 or 0x03, the start is rejected: o_err pulses on the next cycle and the FSM stays in IDLE.
  - i_start while o_busy is ignored silently, with no o_err.
- FSM states: IDLE -> HDR_DLE -> ID -> (ID_STUFF) -> PAYLOAD -> (PL_STUFF) -> TRL_DLE -> ETX -> IDLE.
  - On an accepted start, o_busy=1 from the next cycle.
  - The start bit of the header DLE begins on the cycle after acceptance (latency 1).
  - ID_STUFF and PL_STUFF are entered only if the byte just sent was 0x10; they resend 0x10.
  - With i_len=0, PAYLOAD is skipped: ID -> TRL_DLE.
- Payload handshake:
  - In PAYLOAD, when the serializer is free and a byte is still owed, o_pl_ready=1.
  - A transfer occurs when i_pl_valid&&o_pl_ready. The byte is loaded into the serializer and the payload counter increments.
  - o_pl_ready is deasserted while the serializer is busy and after the final byte.
  - If i_pl_valid is low, o_tx holds high (inter-byte gap); there is no timeout.
- Serializer:
  - Each byte: start bit (0), 8 data bits LSB first, stop bit (1), each held exactly CLKS_PER_BIT cycles.
  - Back-to-back bytes with data available are gapless: the next start bit follows the stop bit directly.
- Completion: o_done pulses the cycle after the final ETX stop bit ends; o_busy falls in that same cycle.
- Counters:
  - Bit-timer width is $clog2(CLKS_PER_BIT).
  - The payload counter is LEN_W bits and counts up to i_len with no wrap.
  - A latched length of 2^LEN_W-1 is legal.

Optional Feature:
- Macro: TSIP_TX_ODD_PARITY_EN.
- Defined: frame is 8-O-1. After data bit 7 an odd-parity bit is inserted (XNOR-reduce of the data byte, so total ones is odd), giving 11 bit-times per byte. Required when the Thunderbolt is configured 9600 8-O-1.
- Undefined: 8-N-1, 10 bit-times per byte, and no parity logic is synthesised.

Decomposition:
- Shared package tsip_pkg: constants TSIP_DLE=8'h10, TSIP_ETX=8'h03, TSIP_ID_TIMING=8'h8F, TSIP_SUB_TIMING=8'hAB, plus the FSM state encoding.
- The existing receiver is to import tsip_pkg as well.
- One natural sub-module: uart_tx_byte (CLKS_PER_BIT).
  - Ports: i_clk, i_rst_n, i_send, i_byte, o_busy, o_tx.
  - Parity is under the same macro.
  - tsip_packet_tx holds only framing and stuffing control.

Test Plan:
- CLKS_PER_BIT=4, i_id=0x8E, i_len=2, payload {0xAB,0x10} presented immediately -> wire bytes 10 8E AB 10 10 10 03; 70 bit-times = 280 cycles from first start bit; o_done pulses once.
- i_len=0, i_id=0x1F -> wire 10 1F 10 03; o_pl_ready never asserts.
- i_id=0x10 -> o_err pulse; o_tx stays high; o_busy stays 0.
- Payload of 3 bytes with i_pl_valid withheld 37 cycles before the 2nd byte -> o_tx high through the gap; byte values intact; total time extended by exactly the gap.
- i_rst_n asserted during the ID byte's data bits -> o_tx=1 immediately; after release, a new i_start sends a complete, correct packet.
- With TSIP_TX_ODD_PARITY_EN: payload 0x00 -> parity bit 1; payload 0x01 -> parity bit 0; 11 bit-times per byte.
